// File: rtl/power_gesture_if.sv
// power_gesture_if: raw button inputs, timing configuration and status outputs of power_gesture_ctrl
interface power_gesture_if #(parameter int CNT_W = 30);
  logic power_button, left_button, right_button;
  logic [CNT_W-1:0] gesture_time, idle_time;
  logic power_status, power_on_pulse, power_off_pulse, gesture_armed;
  modport master (
    output power_button, left_button, right_button, gesture_time, idle_time,
    input power_status, power_on_pulse, power_off_pulse, gesture_armed
  );
  modport slave (
    input power_button, left_button, right_button, gesture_time, idle_time,
    output power_status, power_on_pulse, power_off_pulse, gesture_armed
  );
endinterface

// File: rtl/power_gesture_ctrl.sv
// power_gesture_ctrl: debounced power-button and left/right gesture on/off controller.
// Optional idle auto-off is built when AUTO_OFF_EN is defined.
module power_gesture_ctrl #(
  parameter int CNT_W = 30,
  parameter int DEBOUNCE_CYC = 20_000_000,
  parameter int LONG_PRESS_CYC = 300_000_000
) (
  input logic clk,
  input logic rst,
  power_gesture_if.slave bus
);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LP = CNT_W'(LONG_PRESS_CYC);
  typedef enum logic {G_IDLE, G_ARMED} g_state_t;
  g_state_t g_state;
  logic [2:0] s1, s2, db, db_q, rise, fall;
  logic [CNT_W-1:0] db_cnt [3];
  logic [CNT_W-1:0] hold_cnt, win_cnt;
  logic long_seen, on, on_p, off_p;
  logic gt_ok, both, long_evt, short_evt, arm_evt, comp_evt, auto_evt, go_on, go_off;
  // bit 0 power, bit 1 left, bit 2 right
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      db_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= {bus.right_button, bus.left_button, bus.power_button};
      s2 <= s1;
      db_q <= db;
      for (int i = 0; i < 3; i++)
        if (s2[i] == db[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] >= DB_MAX) begin
          db_cnt[i] <= '0;
          db[i] <= s2[i];
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
    end
  assign rise = db & ~db_q;
  assign fall = ~db & db_q;
  assign gt_ok = bus.gesture_time != '0;
  assign both = rise[1] & rise[2];
  // long_seen makes the long-press decision fire once per hold despite saturation
  assign long_evt = on && hold_cnt == LP && !long_seen;
  assign short_evt = !on && fall[0] && hold_cnt < LP;
  assign arm_evt = gt_ok && (on ? rise[2] : rise[1]);
  assign comp_evt = gt_ok && g_state == G_ARMED && !both && (on ? rise[1] : rise[2]);
  assign go_off = on && (long_evt || comp_evt || auto_evt);
  assign go_on = !on && (comp_evt || short_evt);
`ifdef AUTO_OFF_EN
  logic [CNT_W-1:0] idle_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) idle_cnt <= '0;
    else idle_cnt <= (!on || db != '0 || go_on || go_off) ? '0 : idle_cnt == '1 ? idle_cnt : idle_cnt + 1'b1;
  assign auto_evt = bus.idle_time != '0 && idle_cnt >= bus.idle_time;
`else
  logic unused_idle;
  assign unused_idle = ^bus.idle_time;
  assign auto_evt = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      on <= 1'b0;
      on_p <= 1'b0;
      off_p <= 1'b0;
      hold_cnt <= '0;
      long_seen <= 1'b0;
      win_cnt <= '0;
      g_state <= G_IDLE;
    end else begin
      on_p <= go_on;
      off_p <= go_off;
      if (go_on || go_off) on <= go_on;
      hold_cnt <= !db[0] ? '0 : hold_cnt == LP ? LP : hold_cnt + 1'b1;
      long_seen <= hold_cnt == LP;
      if (go_on || go_off) g_state <= G_IDLE;
      else if (arm_evt) begin
        g_state <= G_ARMED;
        win_cnt <= '0;
      end else if (g_state == G_ARMED && (!gt_ok || win_cnt == bus.gesture_time - 1'b1)) g_state <= G_IDLE;
      else if (win_cnt != '1) win_cnt <= win_cnt + 1'b1;
    end
  assign bus.power_status = on;
  assign bus.power_on_pulse = on_p;
  assign bus.power_off_pulse = off_p;
  assign bus.gesture_armed = g_state == G_ARMED;
endmodule
